// File: rtl/wts_channel_scheduler_if.sv
// Register-side and generator-side signals of the wave table channel scheduler.
// The master drives enable and requests; the scheduler (slave) drives the slot outputs.
interface wts_channel_scheduler_if;
    logic       enable;
    logic [4:0] reset_req;
    logic [2:0] active;
    logic       address_reset;
    logic       frame_start;
    logic       sample_strobe;
    logic [4:0] reset_pending;

    modport master (
        output enable, reset_req,
        input  active, address_reset, frame_start, sample_strobe, reset_pending
    );

    modport slave (
        input  enable, reset_req,
        output active, address_reset, frame_start, sample_strobe, reset_pending
    );
endinterface

// File: rtl/wts_channel_scheduler.sv
// Frame sequencer: one update slot per channel A..E per frame, then idle slots.
// Latched address-reset requests are delivered as a pulse on the owning channel's slot.
module wts_channel_scheduler #(
    parameter int unsigned FRAME_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    wts_channel_scheduler_if.slave      bus
);

    localparam int unsigned CW     = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned NCH    = 5;
    localparam logic [CW-1:0] C_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [2:0]    IDLE   = 3'd7;

    typedef enum logic {
        ST_PARK,
        ST_RUN
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   c_q, c_d;
    logic [NCH-1:0]  pending_q, pending_d;
    logic [2:0]      active_q, active_d;
    logic            address_reset_q, address_reset_d;
    logic            frame_start_q, frame_start_d;
    logic            sample_strobe_q, sample_strobe_d;
    logic            slot_live;

    // Leaving park counts as slot 0 of a new frame, so the first frame starts immediately.
    always_comb begin
        state_d         = state_q;
        c_d             = c_q;
        pending_d       = pending_q;
        active_d        = IDLE;
        address_reset_d = 1'b0;
        frame_start_d   = 1'b0;
        sample_strobe_d = 1'b0;
        slot_live       = 1'b0;

        unique case (state_q)
            ST_PARK: begin
                c_d = '0;
                if (bus.enable) begin
                    slot_live = 1'b1;
                    state_d   = ST_RUN;
                    c_d       = CW'(1);
                end
            end
            ST_RUN: begin
                slot_live = 1'b1;
                if (c_q == C_LAST) begin
                    c_d = '0;
                    if (!bus.enable) begin
                        state_d = ST_PARK;
                    end
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_PARK;
                c_d     = '0;
            end
        endcase

        if (slot_live) begin
            active_d        = (c_q < CW'(NCH)) ? 3'(c_q) : IDLE;
            frame_start_d   = (c_q == '0);
            sample_strobe_d = (c_q == CW'(NCH));
        end

        // A request coinciding with its own service slot merges into that service.
        for (int i = 0; i < int'(NCH); i++) begin
            if (slot_live && (c_q == CW'(i)) && pending_q[i]) begin
                pending_d[i]    = 1'b0;
                address_reset_d = 1'b1;
            end else begin
                pending_d[i] = pending_q[i] | bus.reset_req[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_PARK;
            c_q             <= '0;
            pending_q       <= '0;
            active_q        <= IDLE;
            address_reset_q <= 1'b0;
            frame_start_q   <= 1'b0;
            sample_strobe_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            c_q             <= c_d;
            pending_q       <= pending_d;
            active_q        <= active_d;
            address_reset_q <= address_reset_d;
            frame_start_q   <= frame_start_d;
            sample_strobe_q <= sample_strobe_d;
        end
    end

    assign bus.active        = active_q;
    assign bus.address_reset = address_reset_q;
    assign bus.frame_start   = frame_start_q;
    assign bus.sample_strobe = sample_strobe_q;
    assign bus.reset_pending = pending_q;

endmodule
